// File: rtl/ir_scan_sequencer.sv
// IR beacon scan sequencer: steps through four IR emitter channels, counts receiver edges per channel,
// and reports the strongest channel. Define IR_BLINK_FILTER_EN to add a 3-sample majority glitch filter.
module ir_scan_sequencer #(
    parameter int DWELL     = 1000,
    parameter int SETTLE    = 16,
    parameter int MIN_EDGES = 3,
    parameter int CNT_W     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       blinky,
    output logic [3:0] IRlights,
    output logic       busy,
    output logic       finalDone,
    output logic [2:0] finalAnswer,
    output logic [1:0] o_dbg_state
);

    localparam int TMAX = (DWELL > SETTLE) ? DWELL : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DWELL  = 2'd2,
        S_DECIDE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [TW-1:0]    r_timer;
    logic [1:0]       r_ch;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_best_cnt;
    logic [1:0]       r_best_ch;
    logic [1:0]       r_sync;
    logic             r_prev;
    logic             r_done;
    logic [2:0]       r_answer;
    logic             w_sig;
    logic             w_rise;
    logic             w_settle_last;
    logic             w_dwell_last;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef IR_BLINK_FILTER_EN
    logic [1:0] r_fhist;
    logic       r_filt;
    logic       w_maj;

    // Majority of the current and two previous synced samples; a lone 1-cycle pulse never wins.
    assign w_maj = (r_sync[1] & r_fhist[0]) | (r_sync[1] & r_fhist[1]) | (r_fhist[0] & r_fhist[1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fhist <= 2'b00;
            r_filt  <= 1'b0;
        end else begin
            r_fhist <= {r_fhist[0], r_sync[1]};
            r_filt  <= w_maj;
        end
    end

    assign w_sig = r_filt;
`else
    assign w_sig = r_sync[1];
`endif

    assign w_rise        = w_sig & ~r_prev;
    assign w_settle_last = (r_timer == TW'(SETTLE - 1));
    assign w_dwell_last  = (r_timer == TW'(DWELL - 1));
    assign w_cnt_next    = (w_rise && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SETTLE;
            S_SETTLE: if (w_settle_last) w_next = S_DWELL;
            S_DWELL:  if (w_dwell_last) w_next = (r_ch == 2'd3) ? S_DECIDE : S_SETTLE;
            S_DECIDE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync     <= 2'b00;
            r_prev     <= 1'b0;
            r_timer    <= '0;
            r_ch       <= 2'd0;
            r_cnt      <= '0;
            r_best_cnt <= '0;
            r_best_ch  <= 2'd0;
            r_done     <= 1'b0;
            r_answer   <= 3'd0;
        end else begin
            r_sync <= {r_sync[0], blinky};
            r_prev <= w_sig;
            r_done <= (r_state == S_DECIDE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_timer    <= '0;
                        r_ch       <= 2'd0;
                        r_cnt      <= '0;
                        r_best_cnt <= '0;
                        r_best_ch  <= 2'd0;
                    end
                end
                S_SETTLE: begin
                    r_timer <= w_settle_last ? '0 : r_timer + TW'(1);
                end
                S_DWELL: begin
                    r_cnt   <= w_cnt_next;
                    r_timer <= r_timer + TW'(1);
                    if (w_dwell_last) begin
                        r_timer <= '0;
                        // Strictly greater only, so a tie keeps the earlier (lower) channel.
                        if (w_cnt_next > r_best_cnt) begin
                            r_best_cnt <= w_cnt_next;
                            r_best_ch  <= r_ch;
                        end
                        if (r_ch != 2'd3) begin
                            r_ch  <= r_ch + 2'd1;
                            r_cnt <= '0;
                        end
                    end
                end
                S_DECIDE: begin
                    r_answer <= (r_best_cnt >= CNT_W'(MIN_EDGES)) ? ({1'b0, r_best_ch} + 3'd1) : 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign IRlights    = ((r_state == S_SETTLE) || (r_state == S_DWELL)) ? (4'b0001 << r_ch) : 4'b0000;
    assign busy        = (r_state != S_IDLE);
    assign finalDone   = r_done;
    assign finalAnswer = r_answer;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ir_scan_sequencer.sv
// Directed bench for ir_scan_sequencer: per-scenario tasks with hand-computed expectations.
module tb_ir_scan_sequencer;

    localparam int DWELL    = 100;
    localparam int SETTLE   = 4;
    localparam int MIN_E    = 3;
    localparam int WIN      = SETTLE + DWELL;
    localparam int DONE_LAT = 4 * WIN + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       blinky = 1'b0;
    logic [3:0] IRlights;
    logic       busy;
    logic       finalDone;
    logic [2:0] finalAnswer;
    logic [1:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int edges[4];
    bit glitch  = 1'b0;

    ir_scan_sequencer #(
        .DWELL(DWELL), .SETTLE(SETTLE), .MIN_EDGES(MIN_E), .CNT_W(10)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .blinky(blinky),
        .IRlights(IRlights), .busy(busy), .finalDone(finalDone),
        .finalAnswer(finalAnswer), .o_dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Stimulus for cycle k after start acceptance: pulses begin at offset 10 of each channel window.
    function automatic logic blink_at(int k);
        int w, d;
        w = k / WIN;
        if (w > 3) return 1'b0;
        d = (k % WIN) - 10;
        if (d < 0 || d >= 4 * edges[w]) return 1'b0;
        return glitch ? ((d % 4) == 0) : ((d % 4) < 2);
    endfunction

    task automatic set_edges(input int e0, input int e1, input int e2, input int e3, input bit g);
        edges[0] = e0; edges[1] = e1; edges[2] = e2; edges[3] = e3;
        glitch   = g;
    endtask

    task automatic run_scan(input string name, input logic [2:0] exp_ans, input bit mid_start);
        int         pulses;
        int         done_at;
        logic [3:0] exp_l;
        pulses  = 0;
        done_at = -1;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_total++;
        if (IRlights !== 4'b0001) $display("FAIL %s_irlights_first: got %b expected 0001", name, IRlights);
        else n_pass++;
        for (int k = 0; k < 430; k++) begin
            blinky = blink_at(k);
            if (mid_start) start = (k == 200 || k == 416);
            if ((k % WIN) == 50 && (k / WIN) < 4) begin
                exp_l = 4'(4'b0001 << (k / WIN));
                n_total++;
                if (IRlights !== exp_l || busy !== 1'b1)
                    $display("FAIL %s_irlights_k%0d: got %b busy %b expected %b busy 1", name, k, IRlights, busy, exp_l);
                else n_pass++;
            end
            @(posedge clock);
            #1;
            if (finalDone === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k + 1;
            end
        end
        start  = 1'b0;
        blinky = 1'b0;
        n_total++;
        if (pulses !== 1) $display("FAIL %s_pulses: got %0d expected 1", name, pulses);
        else n_pass++;
        n_total++;
        if (done_at !== DONE_LAT) $display("FAIL %s_latency: got %0d expected %0d", name, done_at, DONE_LAT);
        else n_pass++;
        n_total++;
        if (finalAnswer !== exp_ans) $display("FAIL %s_answer: got %0d expected %0d", name, finalAnswer, exp_ans);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || IRlights !== 4'b0000)
            $display("FAIL %s_idle_after: got busy %b lights %b expected busy 0 lights 0000", name, busy, IRlights);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            blinky = ~blinky;
            @(posedge clock);
        end
        #1;
        n_total++;
        if (IRlights !== 4'b0000 || busy !== 1'b0 || finalDone !== 1'b0 || finalAnswer !== 3'd0 || dbg_state !== 2'd0)
            $display("FAIL reset_outputs: got lights %b busy %b done %b ans %0d state %0d expected all 0",
                     IRlights, busy, finalDone, finalAnswer, dbg_state);
        else n_pass++;
        @(negedge clock);
        reset  = 1'b0;
        start  = 1'b0;
        blinky = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_stays_idle: got busy %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_beacon();
        set_edges(0, 0, 10, 0, 1'b0);
        run_scan("single_beacon", 3'd3, 1'b0);
    endtask

    task automatic test_no_beacon();
        set_edges(0, 0, 0, 0, 1'b0);
        run_scan("no_activity", 3'd0, 1'b0);
        set_edges(2, 2, 2, 2, 1'b0);
        run_scan("below_min", 3'd0, 1'b0);
    endtask

    task automatic test_threshold();
        set_edges(0, 3, 1, 2, 1'b0);
        run_scan("exact_min", 3'd2, 1'b0);
    endtask

    task automatic test_tie_and_ignored_start();
        set_edges(5, 1, 5, 1, 1'b0);
        run_scan("tie_low_wins", 3'd1, 1'b1);
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        set_edges(0, 5, 0, 0, 1'b0);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 0; k < 150; k++) begin
            blinky = blink_at(k);
            @(posedge clock);
            #1;
            if (finalDone === 1'b1) pulses++;
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        n_total++;
        if (IRlights !== 4'b0000 || busy !== 1'b0 || finalDone !== 1'b0 || finalAnswer !== 3'd0)
            $display("FAIL abort_outputs: got lights %b busy %b done %b ans %0d expected all 0",
                     IRlights, busy, finalDone, finalAnswer);
        else n_pass++;
        reset  = 1'b0;
        start  = 1'b0;
        blinky = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (finalDone === 1'b1) pulses++;
        end
        n_total++;
        if (pulses !== 0 || busy !== 1'b0)
            $display("FAIL abort_no_done: got pulses %0d busy %b expected pulses 0 busy 0", pulses, busy);
        else n_pass++;
        set_edges(0, 0, 0, 4, 1'b0);
        run_scan("after_abort", 3'd4, 1'b0);
    endtask

    task automatic test_glitch_filter();
        logic [2:0] exp_ans;
`ifdef IR_BLINK_FILTER_EN
        exp_ans = 3'd0;
`else
        exp_ans = 3'd1;
`endif
        set_edges(6, 0, 0, 0, 1'b1);
        run_scan("glitches", exp_ans, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_beacon();
        test_no_beacon();
        test_threshold();
        test_tie_and_ignored_start();
        test_reset_abort();
        test_glitch_filter();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ir_scan_sequencer.md
IR_SCAN_SEQUENCER -- requirements
Module: ir_scan_sequencer

Interface
REQ-001 Parameter DWELL, default 1000: cycles each IR channel is counted after settling.
REQ-002 Parameter SETTLE, default 16: cycles after channel switch during which blinky edges are ignored.
REQ-003 Parameter MIN_EDGES, default 3: minimum edge count for a channel to qualify as a beacon.
REQ-004 Parameter CNT_W, default 10: width of the edge counter and the best-count register.
REQ-005 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: scan request, sampled only in IDLE.
REQ-008 Port blinky, input, 1: asynchronous IR receiver output.
REQ-009 Port IRlights, output, 4: one-hot IR emitter enables.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port finalDone, output, 1: single-cycle scan-complete pulse.
REQ-012 Port finalAnswer, output, 3: 0 = no beacon; 1..4 = winning channel index + 1.

Function
REQ-013 blinky passes through a 2-flop synchronizer; a rising edge is synced=1 while the previous synced sample = 0.
REQ-014 FSM states: IDLE, SETTLE, DWELL, DECIDE; channel register ch is 2 bits.
REQ-015 IDLE: start=1 -> SETTLE with ch=0, edge counter=0, best count=0, best channel=0.
REQ-016 SETTLE lasts exactly SETTLE cycles, edges are not counted, then -> DWELL.
REQ-017 DWELL lasts exactly DWELL cycles; each detected rising edge increments the edge counter, saturating at 2^CNT_W-1.
REQ-018 At DWELL end the final count, including an edge detected in the last DWELL cycle, is compared with best count; only a strictly greater count replaces best count and best channel, so ties keep the lower channel.
REQ-019 At DWELL end: ch<3 -> ch+1, clear edge counter, -> SETTLE; ch=3 -> DECIDE.
REQ-020 DECIDE lasts one cycle: finalAnswer = best channel+1 if best count >= MIN_EDGES, else 0; finalDone=1; -> IDLE.
REQ-021 finalAnswer holds its value until the next DECIDE or reset.
REQ-022 IRlights = one-hot(ch) in SETTLE and DWELL, and 4'b0000 in IDLE and DECIDE.
REQ-023 IRlights goes high the cycle after start is accepted; finalDone asserts 4*(SETTLE+DWELL)+1 cycles after start is accepted.
REQ-024 start is ignored while busy=1, including during the DECIDE cycle, and does not restart or queue a scan.

Reset
REQ-025 reset=1 at a clock edge forces IDLE, ch=0, all counters 0, synchronizer flops 0, IRlights=0, busy=0, finalDone=0, finalAnswer=0.
REQ-026 reset mid-scan aborts without a finalDone pulse; reset overrides start in the same cycle.

Configuration
REQ-027 With macro IR_BLINK_FILTER_EN defined, a 3-sample majority filter after the synchronizer feeds edge detection, adding 2 cycles of latency and rejecting pulses of 1 cycle.
REQ-028 Without IR_BLINK_FILTER_EN, the synchronizer feeds edge detection directly and every synced rising edge is counted.

Verification (DWELL=100, SETTLE=4, MIN_EDGES=3, filter off unless noted)
REQ-029 Hold reset for 2 cycles with blinky toggling -> IRlights=0, busy=0, finalDone=0, finalAnswer=0.
REQ-030 Toggle blinky for 10 edges only while IRlights=4'b0100 -> finalAnswer=3 and exactly one finalDone pulse, 417 cycles after start.
REQ-031 No blinky activity, or 2 edges on every channel -> finalAnswer=0 and finalDone pulses once.
REQ-032 5 edges on channels 0 and 2, 1 edge elsewhere -> finalAnswer=1; start pulsed mid-scan has no effect.
REQ-033 Assert reset during DWELL on channel 1 -> IRlights=0 and busy=0 the next cycle, with no finalDone; a new start then runs a full 4-channel scan.
REQ-034 IR_BLINK_FILTER_EN defined, 6 single-cycle glitches on channel 0 -> finalAnswer=0; same stimulus without the macro -> finalAnswer=1.
